// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data memory access unit: size codes,
// controller states and the byte-enable lane pattern.
package mem_access_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_HALF = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Byte enables for an access of the given size at byte lane 'lane'.
    function automatic logic [3:0] be_pattern(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be_v;
        be_v = 4'b0000;
        case (size)
            SZ_WORD: be_v = 4'b1111;
            SZ_HALF: be_v = lane[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be_v = 4'b0001 << lane;
            default: be_v = 4'b0000;
        endcase
        return be_v;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane alignment. With is_load=0 it replicates store data onto
// every lane of its size; with is_load=1 it picks the addressed byte/half out
// of a memory word and sign-extends it. be is the lane pattern in both modes.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_load,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic [31:0] data_out
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half of the incoming word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane)
            2'b00:   byte_s = data_in[7:0];
            2'b01:   byte_s = data_in[15:8];
            2'b10:   byte_s = data_in[23:16];
            2'b11:   byte_s = data_in[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = data_in[31:16];
        end else begin
            half_s = data_in[15:0];
        end
    end

    // Produce steered store data or the sign-extended load value.
    always_comb begin
        be       = be_pattern(size, lane);
        data_out = 32'h0000_0000;
        if (is_load) begin
            case (size)
                SZ_WORD: data_out = data_in;
                SZ_HALF: data_out = {{16{half_s[15]}}, half_s};
                SZ_BYTE: data_out = {{24{byte_s[7]}}, byte_s};
                default: data_out = 32'h0000_0000;
            endcase
        end else begin
            case (size)
                SZ_WORD: data_out = data_in;
                SZ_HALF: data_out = {2{data_in[15:0]}};
                SZ_BYTE: data_out = {4{data_in[7:0]}};
                default: data_out = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory responder: accepts a load/store size code, runs one
// req/ack bus transaction with a timeout, and stalls the pipeline meanwhile.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        cmd_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_r;
    state_e             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [1:0]         rd_size_r;
    logic [1:0]         rd_size_next_s;
    logic [1:0]         lane_r;
    logic [1:0]         lane_next_s;

    logic [31:0]        rdata_next_s;
    logic               done_next_s;
    logic               mis_next_s;
    logic               cmd_err_next_s;
    logic               bus_err_next_s;
    logic               req_next_s;
    logic               we_next_s;
    logic [31:0]        addr_next_s;
    logic [3:0]         be_next_s;
    logic [31:0]        wdata_next_s;

    logic               cmd_present_s;
    logic               conflict_s;
    logic               is_load_cmd_s;
    logic [1:0]         cmd_size_s;
    logic               misalign_s;
    logic               accept_s;
    logic               timeout_s;

    logic [3:0]         store_be_s;
    logic [31:0]        store_data_s;
    logic [3:0]         load_be_unused_s;
    logic [31:0]        load_data_s;

    assign cmd_present_s = (mem_read != SZ_NONE) || (mem_write != SZ_NONE);
    assign conflict_s    = (mem_read != SZ_NONE) && (mem_write != SZ_NONE);
    assign is_load_cmd_s = (mem_read != SZ_NONE);
    assign cmd_size_s    = is_load_cmd_s ? mem_read : mem_write;
    assign misalign_s    = ((cmd_size_s == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                           ((cmd_size_s == SZ_HALF) && addr[0]);
    assign accept_s      = (state_r == IDLE) && cmd_present_s && !conflict_s && !misalign_s;
    assign timeout_s     = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign stall         = accept_s || (state_r == BUS);

    // Lane pattern and store steering for the incoming command (loads reuse the be).
    mem_lane_align u_store_align (
        .size     (cmd_size_s),
        .lane     (addr[1:0]),
        .is_load  (1'b0),
        .data_in  (wdata),
        .be       (store_be_s),
        .data_out (store_data_s)
    );

    // Extraction of the latched load from the returned memory word.
    mem_lane_align u_load_align (
        .size     (rd_size_r),
        .lane     (lane_r),
        .is_load  (1'b1),
        .data_in  (bus_rdata),
        .be       (load_be_unused_s),
        .data_out (load_data_s)
    );

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        rd_size_next_s = rd_size_r;
        lane_next_s    = lane_r;
        rdata_next_s   = rdata;
        done_next_s    = 1'b0;
        mis_next_s     = 1'b0;
        cmd_err_next_s = 1'b0;
        bus_err_next_s = 1'b0;
        req_next_s     = bus_req;
        we_next_s      = bus_we;
        addr_next_s    = bus_addr;
        be_next_s      = bus_be;
        wdata_next_s   = bus_wdata;
        case (state_r)
            IDLE: begin
                if (cmd_present_s) begin
                    if (conflict_s) begin
                        cmd_err_next_s = 1'b1;
                    end else if (misalign_s) begin
                        mis_next_s = 1'b1;
                    end else begin
                        state_next_s   = BUS;
                        cnt_next_s     = {CNT_W{1'b0}};
                        req_next_s     = 1'b1;
                        we_next_s      = !is_load_cmd_s;
                        addr_next_s    = {addr[31:2], 2'b00};
                        be_next_s      = store_be_s;
                        wdata_next_s   = is_load_cmd_s ? 32'h0000_0000 : store_data_s;
                        rd_size_next_s = mem_read;
                        lane_next_s    = addr[1:0];
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUS: begin
                // The timeout wins over an ack that lands in the same cycle.
                if (timeout_s) begin
                    state_next_s   = DONE;
                    req_next_s     = 1'b0;
                    rdata_next_s   = 32'h0000_0000;
                    done_next_s    = 1'b1;
                    bus_err_next_s = 1'b1;
                end else if (bus_ack) begin
                    state_next_s = DONE;
                    req_next_s   = 1'b0;
                    done_next_s  = 1'b1;
                    if (bus_we) begin
                        rdata_next_s = rdata;
                    end else begin
                        rdata_next_s = load_data_s;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                req_next_s   = 1'b0;
            end
        endcase
    end

    // Controller state and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered bus, status and load-result outputs plus the latched load lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_size_r  <= 2'b00;
            lane_r     <= 2'b00;
            rdata      <= 32'h0000_0000;
            done       <= 1'b0;
            misaligned <= 1'b0;
            cmd_err    <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0000_0000;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'h0000_0000;
        end else begin
            rd_size_r  <= rd_size_next_s;
            lane_r     <= lane_next_s;
            rdata      <= rdata_next_s;
            done       <= done_next_s;
            misaligned <= mis_next_s;
            cmd_err    <= cmd_err_next_s;
            bus_err    <= bus_err_next_s;
            bus_req    <= req_next_s;
            bus_we     <= we_next_s;
            bus_addr   <= addr_next_s;
            bus_be     <= be_next_s;
            bus_wdata  <= wdata_next_s;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory responder for the MEM stage of the pipelined datapath. It consumes the 2-bit MemRead/MemWrite size codes that the main control decoder produces (01 word, 10 byte, 11 half), performs the access on a req/ack memory bus, and returns the loaded data. Loads are sign-extended and stores are byte-lane steered. While an access is in flight the unit stalls the pipeline.

## Interface
- TIMEOUT, 16: maximum number of cycles to wait for bus_ack before aborting.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  2  load size code from the EX/MEM register: 00 none, 01 lw, 10 lb, 11 lh.
- mem_write  in  2  store size code: 00 none, 01 sw, 10 sb, 11 sh.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rt); low byte or half is used for sb/sh.
- rdata  out  32  load result; valid when done=1.
- stall  out  1  holds the pipeline; combinational.
- done  out  1  one-cycle pulse when an access completes.
- misaligned  out  1  one-cycle pulse: the address is not aligned for the requested size.
- cmd_err  out  1  one-cycle pulse: mem_read and mem_write are both nonzero.
- bus_err  out  1  one-cycle pulse: the access timed out.
- bus_req  out  1  memory request; registered.
- bus_we  out  1  1 for a store, 0 for a load.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_rdata  in  32  memory read word.
- bus_ack  in  1  memory completion.

## Operation
- States:
  - IDLE: waiting for a command.
  - BUS: bus request outstanding.
  - DONE: one cycle, result presented.
- In IDLE a command is present when mem_read≠0 or mem_write≠0:
  - Both codes nonzero: pulse cmd_err next cycle, no bus access, stay IDLE.
  - Misaligned (word with addr[1:0]≠0, or half with addr[0]≠0): pulse misaligned next cycle, no bus access, stay IDLE.
  - Otherwise: latch the command, addr and wdata; go to BUS with bus_req=1.
- Byte order is little-endian; the lane is addr[1:0].
- Store lane steering:
  - sw: be=1111, bus_wdata=wdata.
  - sh: be=0011 when addr[1]=0, else 1100; bus_wdata={2{wdata[15:0]}}.
  - sb: be=0001<<addr[1:0]; bus_wdata={4{wdata[7:0]}}.
- Loads drive be to the same lane pattern as stores.
- Load extraction: lw returns bus_rdata as is; lh returns the selected half; lb returns the selected byte. Both lh and lb are sign-extended to 32 bits.
- BUS state:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_ack is sampled high.
  - On ack: capture the extracted load data into rdata, drop bus_req, go to DONE.
  - A cycle counter starts at 0 on entry. If it reaches TIMEOUT-1 with no ack: drop bus_req, rdata=0, pulse bus_err together with done, go to DONE.
- DONE: done=1 and stall=0, so the pipeline advances; next cycle the state is IDLE. The command inputs are ignored during DONE.
- stall = (IDLE and a valid, aligned, non-conflicting command present) or BUS.
- rdata holds its last value until the next load completes; stores leave it unchanged.

## Timing
- Reset value of every output is 0: rdata, done, misaligned, cmd_err, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata. State resets to IDLE and the counter to 0.
- Reset asserted mid-access drops bus_req asynchronously; the pending access is abandoned.
- Latency:
  - Command seen in cycle 0.
  - bus_req high from cycle 1.
  - Ack in cycle k≥1 gives done in cycle k+1.
  - Minimum total stall is 2 cycles.
- bus_ack is ignored outside BUS, including an ack that arrives the same cycle the timeout fires. A timeout takes precedence over a late ack.
- An ack in the first BUS cycle is legal.
- Back-to-back commands: a new command accepted in IDLE starts bus_req at the earliest 2 cycles after the previous done.

## Structure
- mem_access_pkg holds:
  - size constants SZ_NONE=00, SZ_WORD=01, SZ_BYTE=10, SZ_HALF=11.
  - the state enum {IDLE, BUS, DONE}.
  - the be-pattern function.
- Sub-module mem_lane_align: purely combinational. It computes store be/wdata steering and load extraction with sign extension from size, addr[1:0] and data. It is instantiated once for the store path and once for the load path.

## Test plan
- sw addr=0x104, wdata=0xDEADBEEF, ack after 3 cycles -> bus_be=1111, bus_addr=0x104; stall held 4 cycles; done pulses once.
- Memory word 0x80FF7F01 at 0x200: lb at 0x203 -> rdata=0xFFFFFF80; lb at 0x200 -> 0x00000001; lh at 0x202 -> 0xFFFF80FF.
- sb addr=0x11 wdata=0x000000AB -> be=0010, bus_wdata=0xABABABAB; sh addr=0x12 wdata=0x1234 -> be=1100, bus_wdata=0x12341234.
- lw addr=0x102 -> misaligned pulse, bus_req stays 0, stall 0; mem_read=01 with mem_write=01 -> cmd_err pulse only.
- lw with bus_ack never asserted, TIMEOUT=16 -> bus_req drops after 16 cycles; bus_err, done and rdata=0 in the same cycle.
- rst_n pulled low in the 2nd BUS cycle -> bus_req=0 immediately; after release the unit is in IDLE and the next lw completes normally.
